// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Digit-serial in0 - in1 - bin with borrow-out and signed
//                overflow, DIGIT bits per clock behind a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             ovf
);

    localparam int c_NDIG = WIDTH / DIGIT;
    localparam int c_CW   = $clog2(c_NDIG) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_borrow;
    logic              r_a_msb;
    logic              r_b_msb;
    logic [c_CW-1:0]   r_cnt;
    logic              r_done;
    logic [WIDTH-1:0]  r_out;
    logic              r_bout;
    logic              r_ovf;
    logic [DIGIT:0]    w_d;

    // One extra bit on the digit difference captures the outgoing borrow.
    assign w_d = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, r_borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= in0;
                        r_b      <= in1;
                        r_borrow <= bin;
                        r_a_msb  <= in0[WIDTH-1];
                        r_b_msb  <= in1[WIDTH-1];
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // Result fills from the top so the last digit lands in the MSBs.
                    r_res    <= {w_d[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
                    r_borrow <= w_d[DIGIT];
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_cnt    <= r_cnt + c_CW'(1);
                end
                S_FIN: begin
                    r_out  <= r_res;
                    r_bout <= r_borrow;
                    r_ovf  <= (r_a_msb != r_b_msb) && (r_res[WIDTH-1] != r_a_msb);
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign out  = r_out;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// Testbench for serial_subtractor: table vectors, random vectors against a
// full-width model, and handshake/reset corner sequences via a scoreboard.
module tb_serial_subtractor;

    typedef struct {
        logic [15:0] in0;
        logic [15:0] in1;
        logic        bin;
        logic [15:0] out;
        logic        bout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        bout;
    logic        ovf;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] last_out = 16'h0000;
    vec_t        vecs[9];

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in0   (in0),
        .in1   (in1),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        exp_t        e;
        logic [16:0] d;
        d      = {1'b0, a} - {1'b0, b} - {16'h0000, c};
        e.out  = d[15:0];
        e.bout = d[16];
        e.ovf  = (a[15] != b[15]) && (d[15] != a[15]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("out",  32'(out),  32'(mon_e.out));
                chk("bout", 32'(bout), 32'(mon_e.bout));
                chk("ovf",  32'(ovf),  32'(mon_e.ovf));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] eo, input logic eb, input logic ev);
        exp_t e;
        in0   = a;
        in1   = b;
        bin   = c;
        start = 1'b1;
        e.out = eo; e.bout = eb; e.ovf = ev;
        sb.push_back(e);
    endtask

    // Called on the negedge where start was driven; returns on the done negedge.
    task automatic wait_done(input int inject_k, input logic [15:0] eo);
        int lat   = 0;
        int nbusy = 0;
        bit seen  = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            start = (k == inject_k);
            if (k == inject_k) begin
                in0 = 16'h00FF;
                in1 = 16'h0001;
                bin = 1'b1;
            end
            if (k == 1) chk("done_pulse_width", 32'(done), 32'd0);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                lat  = k - 1;
            end else begin
                chk("out_hold", 32'(out), 32'(last_out));
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'd5);
        chk("busy_cycles", 32'(nbusy), 32'd4);
        last_out = eo;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] eo, input logic eb, input logic ev);
        @(negedge clk);
        issue(a, b, c, eo, eb, ev);
        wait_done(0, eo);
    endtask

    initial begin
        exp_t e;
        int   ndone;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        vecs[0] = '{16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[8] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        in0   = 16'h0000;
        in1   = 16'h0000;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out",  32'(out),  32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].in0, vecs[i].in1, vecs[i].bin, vecs[i].out, vecs[i].bout, vecs[i].ovf);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            e  = model(ra, rb, rc);
            run_op(ra, rb, rc, e.out, e.bout, e.ovf);
        end

        // start during RUN is ignored; start in the done cycle is accepted.
        @(negedge clk);
        issue(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        wait_done(2, 16'h0002);
        issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);
        wait_done(0, 16'h000F);

        // Abort in the second RUN cycle.
        @(negedge clk);
        in0 = 16'h0005; in1 = 16'h0003; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out",  32'(out),  32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst_n    = 1'b1;
        last_out = 16'h0000;
        ndone    = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

        @(negedge clk);
        chk("final_done_low", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
